l1_host_arbiter: RTL and testbench

Multi-host front-end for the L1 data interconnect.
- Arbitrates round-robin between `NumHosts` OBI-style data hosts (core data port, future DMA/accelerator masters) onto one interconnect host port.
- Decodes each address against the system memory map and drives the target device index.
- Tracks outstanding transactions in an in-order ID FIFO so every response is routed to the right host.
- Answers unmapped addresses locally with an error response; they are never forwarded.

---
 rtl/l1_bus_pkg.sv | 51 +++++
 rtl/l1_id_fifo.sv | 65 ++++++
 rtl/l1_host_arbiter.sv | 141 ++++++++++++++
 tb/tb_l1_host_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_bus_pkg.sv
// L1 interconnect memory map: device indices, address windows and the shared decoder.
package l1_bus_pkg;

    typedef enum logic [2:0] {
        DEV_RAM     = 3'd0,
        DEV_GPIO    = 3'd1,
        DEV_UART    = 3'd2,
        DEV_TIMER   = 3'd3,
        DEV_FRAISE  = 3'd4,
        DEV_SIMCTRL = 3'd5
    } l1_dev_e;

    localparam logic [31:0] SIMCTRL_START = 32'h0002_0000;
    localparam logic [31:0] SIMCTRL_SIZE  = 32'h0000_0400;
    localparam logic [31:0] RAM_START     = 32'h0010_0000;
    localparam logic [31:0] RAM_SIZE      = 32'h0001_0000;
    localparam logic [31:0] FRAISE_START  = 32'h7000_0000;
    localparam logic [31:0] FRAISE_SIZE   = 32'h0000_1000;
    localparam logic [31:0] GPIO_START    = 32'h8000_0000;
    localparam logic [31:0] GPIO_SIZE     = 32'h0000_1000;
    localparam logic [31:0] UART_START    = 32'h8000_1000;
    localparam logic [31:0] UART_SIZE     = 32'h0000_1000;
    localparam logic [31:0] TIMER_START   = 32'h8000_2000;
    localparam logic [31:0] TIMER_SIZE    = 32'h0000_1000;

    typedef struct packed {
        logic    hit;
        l1_dev_e dev;
    } l1_decode_t;

    // Subtract-then-compare so a window touching the top of the map cannot overflow.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] start,
                                       input logic [31:0] size);
        return (addr >= start) && ((addr - start) < size);
    endfunction

    function automatic l1_decode_t l1_decode(input logic [31:0] addr);
        l1_decode_t res;
        res.hit = 1'b1;
        res.dev = DEV_RAM;
        if (in_window(addr, RAM_START, RAM_SIZE))              res.dev = DEV_RAM;
        else if (in_window(addr, GPIO_START, GPIO_SIZE))       res.dev = DEV_GPIO;
        else if (in_window(addr, UART_START, UART_SIZE))       res.dev = DEV_UART;
        else if (in_window(addr, TIMER_START, TIMER_SIZE))     res.dev = DEV_TIMER;
        else if (in_window(addr, FRAISE_START, FRAISE_SIZE))   res.dev = DEV_FRAISE;
        else if (in_window(addr, SIMCTRL_START, SIMCTRL_SIZE)) res.dev = DEV_SIMCTRL;
        else                                                   res.hit = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/l1_id_fifo.sv
// In-order FIFO of outstanding-transaction tags; push is refused when full, pop when empty.
module l1_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]               count_q, count_d;
    logic [Depth-1:0][Width-1:0] mem_q, mem_d;
    logic                        push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/l1_host_arbiter.sv
// Round-robin multi-host front-end: decodes, forwards mapped requests to the L1 interconnect,
// answers unmapped ones locally and routes in-order responses back through an ID FIFO.
module l1_host_arbiter
    import l1_bus_pkg::*;
#(
    parameter int unsigned NumHosts       = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumHosts-1:0]                    host_req_i,
    output logic [NumHosts-1:0]                    host_gnt_o,
    input  logic [NumHosts-1:0][DataWidth-1:0]     host_addr_i,
    input  logic [NumHosts-1:0]                    host_we_i,
    input  logic [NumHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NumHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NumHosts-1:0]                    host_rvalid_o,
    output logic [NumHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic [NumHosts-1:0]                    host_err_o,
    output logic                                   bus_req_o,
    input  logic                                   bus_ready_i,
    output logic [DataWidth-1:0]                   bus_addr_o,
    output logic [2:0]                             bus_dev_o,
    output logic                                   bus_we_o,
    output logic [DataWidth/8-1:0]                 bus_be_o,
    output logic [DataWidth-1:0]                   bus_wdata_o,
    input  logic                                   bus_rvalid_i,
    input  logic [DataWidth-1:0]                   bus_rdata_i
);

    localparam int unsigned IdW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic           err;
    } id_entry_t;

    logic [IdW-1:0] rr_q, rr_d;
    logic           err_pend_q, err_pend_d;
    logic [IdW-1:0] err_id_q, err_id_d;

    logic [IdW-1:0]       scan_id, cand_id;
    logic                 cand_vld;
    logic [DataWidth-1:0] cand_addr;
    l1_decode_t           dec;
    logic                 fwd, map_gnt, err_gnt;
    logic                 fifo_full, fifo_empty, fifo_pop;
    id_entry_t            push_entry, head;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        scan_id  = '0;
        cand_id  = '0;
        cand_vld = 1'b0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            scan_id = IdW'((32'(rr_q) + i) % NumHosts);
            if (!cand_vld && host_req_i[scan_id]) begin
                cand_vld = 1'b1;
                cand_id  = scan_id;
            end
        end
    end

    assign cand_addr = host_addr_i[cand_id];
    assign dec       = l1_decode(32'(cand_addr));

    assign fwd        = cand_vld && dec.hit && !fifo_full;
    assign map_gnt    = fwd && bus_ready_i;
    // Unmapped requests wait for an idle pipe so their error lands in order.
    assign err_gnt    = cand_vld && !dec.hit && fifo_empty && !err_pend_q;
    assign fifo_pop   = bus_rvalid_i && !fifo_empty;
    assign push_entry = '{id: cand_id, err: 1'b0};

    always_comb begin
        rr_d       = rr_q;
        err_pend_d = err_gnt;
        err_id_d   = err_gnt ? cand_id : err_id_q;
        if (map_gnt || err_gnt) begin
            rr_d = (cand_id == IdW'(NumHosts - 1)) ? '0 : cand_id + 1'b1;
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (map_gnt || err_gnt) begin
            host_gnt_o[cand_id] = 1'b1;
        end
        bus_req_o   = fwd;
        bus_addr_o  = fwd ? cand_addr : '0;
        bus_dev_o   = fwd ? dec.dev : 3'd0;
        bus_we_o    = fwd ? host_we_i[cand_id] : 1'b0;
        bus_be_o    = fwd ? host_be_i[cand_id] : '0;
        bus_wdata_o = fwd ? host_wdata_i[cand_id] : '0;
        if (fifo_pop) begin
            host_rvalid_o[head.id] = 1'b1;
            host_err_o[head.id]    = head.err;
            for (int unsigned h = 0; h < NumHosts; h++) begin
                host_rdata_o[h] = bus_rdata_i;
            end
        end
        if (err_pend_q) begin
            host_rvalid_o[err_id_q] = 1'b1;
            host_err_o[err_id_q]    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            err_pend_q <= 1'b0;
            err_id_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            err_pend_q <= err_pend_d;
            err_id_q   <= err_id_d;
        end
    end

    l1_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW + 1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (map_gnt),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A response with nothing outstanding has no owner and is dropped.
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_l1_host_arbiter.sv
// Directed bench for l1_host_arbiter with a queue-based reference model checked every cycle.
module tb_l1_host_arbiter;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NH-1:0]          host_req;
    logic [NH-1:0]          host_gnt;
    logic [NH-1:0][DW-1:0]  host_addr;
    logic [NH-1:0]          host_we;
    logic [NH-1:0][3:0]     host_be;
    logic [NH-1:0][DW-1:0]  host_wdata;
    logic [NH-1:0]          host_rvalid;
    logic [NH-1:0][DW-1:0]  host_rdata;
    logic [NH-1:0]          host_err;
    logic                   bus_req;
    logic                   bus_ready;
    logic [DW-1:0]          bus_addr;
    logic [2:0]             bus_dev;
    logic                   bus_we;
    logic [3:0]             bus_be;
    logic [DW-1:0]          bus_wdata;
    logic                   bus_rvalid;
    logic [DW-1:0]          bus_rdata;

    l1_host_arbiter #(
        .NumHosts       (NH),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_addr_i   (host_addr),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .host_err_o    (host_err),
        .bus_req_o     (bus_req),
        .bus_ready_i   (bus_ready),
        .bus_addr_o    (bus_addr),
        .bus_dev_o     (bus_dev),
        .bus_we_o      (bus_we),
        .bus_be_o      (bus_be),
        .bus_wdata_o   (bus_wdata),
        .bus_rvalid_i  (bus_rvalid),
        .bus_rdata_i   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory map table, index = device code.
    localparam logic [31:0] WIN_ST [6] = '{32'h0010_0000, 32'h8000_0000, 32'h8000_1000,
                                          32'h8000_2000, 32'h7000_0000, 32'h0002_0000};
    localparam logic [31:0] WIN_SZ [6] = '{32'h0001_0000, 32'h0000_1000, 32'h0000_1000,
                                          32'h0000_1000, 32'h0000_1000, 32'h0000_0400};

    typedef struct {
        logic [NH-1:0]         gnt;
        logic [NH-1:0]         rvalid;
        logic [NH-1:0]         err;
        logic [NH-1:0][DW-1:0] rdata;
        logic                  bus_req;
        logic [2:0]            dev;
        logic [DW-1:0]         addr;
        logic [DW-1:0]         wdata;
        logic                  we;
        logic [3:0]            be;
        int                    cand;
        bit                    mgnt;
        bit                    egnt;
        bit                    pop;
    } exp_t;

    // Reference state: pointer, queue of host ids in flight, pending local error.
    int   m_rr    = 0;
    int   m_q[$];
    bit   m_errp  = 0;
    int   m_errid = 0;

    function automatic exp_t eval();
        exp_t       e;
        bit         hit;
        logic [2:0] dev;
        e.gnt = '0; e.rvalid = '0; e.err = '0; e.rdata = '0;
        e.bus_req = 0; e.dev = 0; e.addr = 0; e.wdata = 0; e.we = 0; e.be = 0;
        e.cand = -1; e.mgnt = 0; e.egnt = 0; e.pop = 0;
        hit = 0; dev = 0;
        for (int i = 0; i < NH; i++) begin
            int h;
            h = (m_rr + i) % NH;
            if (e.cand < 0 && host_req[h]) e.cand = h;
        end
        if (e.cand >= 0) begin
            for (int k = 0; k < 6; k++) begin
                if (host_addr[e.cand] >= WIN_ST[k] && host_addr[e.cand] < WIN_ST[k] + WIN_SZ[k]) begin
                    hit = 1;
                    dev = 3'(k);
                end
            end
            e.bus_req = hit && (m_q.size() < MO);
            e.mgnt    = e.bus_req && bus_ready;
            e.egnt    = !hit && (m_q.size() == 0) && !m_errp;
            if (e.bus_req) begin
                e.addr  = host_addr[e.cand];
                e.dev   = dev;
                e.we    = host_we[e.cand];
                e.be    = host_be[e.cand];
                e.wdata = host_wdata[e.cand];
            end
            if (e.mgnt || e.egnt) e.gnt[e.cand] = 1'b1;
        end
        e.pop = bus_rvalid && (m_q.size() > 0);
        if (e.pop) begin
            e.rvalid[m_q[0]] = 1'b1;
            e.rdata = {NH{bus_rdata}};
        end
        if (m_errp) begin
            e.rvalid[m_errid] = 1'b1;
            e.err[m_errid]    = 1'b1;
        end
        return e;
    endfunction

    exp_t upd_e;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr    <= 0;
            m_errp  <= 0;
            m_errid <= 0;
            m_q.delete();
        end else begin
            upd_e = eval();
            if (upd_e.pop) void'(m_q.pop_front());
            if (upd_e.mgnt) m_q.push_back(upd_e.cand);
            m_errp <= upd_e.egnt;
            if (upd_e.egnt) m_errid <= upd_e.cand;
            if (upd_e.mgnt || upd_e.egnt) m_rr <= (upd_e.cand + 1) % NH;
        end
    end

    exp_t          ce;
    logic [NH-1:0] cur_gnt;
    always @(negedge clk) begin
        ce = eval();
        cur_gnt <= ce.gnt;
        chk("gnt",       host_gnt,    ce.gnt);
        chk("rvalid",    host_rvalid, ce.rvalid);
        chk("err",       host_err,    ce.err);
        chk("rdata",     host_rdata,  ce.rdata);
        chk("bus_req",   bus_req,     ce.bus_req);
        chk("bus_addr",  bus_addr,    ce.addr);
        chk("bus_dev",   bus_dev,     ce.dev);
        chk("bus_we",    bus_we,      ce.we);
        chk("bus_be",    bus_be,      ce.be);
        chk("bus_wdata", bus_wdata,   ce.wdata);
    end

    // Advance one cycle; a granted host drops its request.
    task automatic cyc();
        logic [NH-1:0] g;
        @(posedge clk);
        g = cur_gnt;
        #1;
        host_req = host_req & ~g;
    endtask

    task automatic issue(input int h, input logic [31:0] a, input logic we, input logic [31:0] wd);
        host_addr[h]  = a;
        host_we[h]    = we;
        host_be[h]    = 4'hF;
        host_wdata[h] = wd;
        host_req[h]   = 1'b1;
    endtask

    task automatic respond(input logic [31:0] d);
        bus_rvalid = 1'b1;
        bus_rdata  = d;
    endtask

    task automatic idle_bus();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
    endtask

    initial begin
        rst_n = 1'b0; host_req = '0; host_addr = '0; host_we = '0; host_be = '0;
        host_wdata = '0; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("rst_gnt", host_gnt, 2'b00);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_rvalid", host_rvalid, 2'b00);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Mapped read to Ram, response two cycles after the grant.
        issue(0, 32'h0010_0010, 1'b0, 32'h0);
        @(negedge clk);
        chk("rd_gnt", host_gnt, 2'b01);
        chk("rd_dev", bus_dev, 3'd0);
        chk("rd_addr", bus_addr, 32'h0010_0010);
        cyc();
        cyc();
        respond(32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_rvalid", host_rvalid, 2'b01);
        chk("rd_rdata", host_rdata[0], 32'hDEAD_BEEF);
        cyc();
        idle_bus();

        // Host1 write to Timer returns the pointer to host0.
        issue(1, 32'h8000_2010, 1'b1, 32'hCAFE_0001);
        @(negedge clk);
        chk("tmr_gnt", host_gnt, 2'b10);
        chk("tmr_dev", bus_dev, 3'd3);
        chk("tmr_wdata", bus_wdata, 32'hCAFE_0001);
        cyc();
        respond(32'h0);
        cyc();
        idle_bus();

        // Both hosts hammer Gpio.
        for (int k = 0; k < 4; k++) begin
            issue(0, 32'h8000_0004, 1'b0, 32'h0);
            issue(1, 32'h8000_0004, 1'b0, 32'h0);
            @(negedge clk);
            chk("rr_gnt", host_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_dev", bus_dev, 3'd1);
            cyc();
        end
        host_req = '0;
        for (int k = 0; k < 4; k++) begin
            respond(32'h1000 + k);
            @(negedge clk);
            chk("rr_rvalid", host_rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        idle_bus();

        // Backpressure on a Uart request from host1.
        bus_ready = 1'b0;
        issue(1, 32'h8000_1000, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_gnt", host_gnt, 2'b00);
            chk("bp_req", bus_req, 1'b1);
            chk("bp_dev", bus_dev, 3'd2);
            cyc();
        end
        bus_ready = 1'b1;
        @(negedge clk);
        chk("bp_gnt_rise", host_gnt, 2'b10);
        cyc();
        respond(32'h55);
        @(negedge clk);
        chk("bp_rvalid", host_rvalid, 2'b10);
        cyc();
        idle_bus();

        // Fill the ID FIFO and verify the fifth request waits for a pop.
        for (int k = 0; k < 4; k++) begin
            issue(0, 32'h0010_0100 + 4 * k, 1'b1, 32'hA0 + k);
            @(negedge clk);
            chk("full_gnt", host_gnt, 2'b01);
            cyc();
        end
        issue(0, 32'h0010_0200, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_req", bus_req, 1'b0);
            chk("full_hold", host_gnt, 2'b00);
            cyc();
        end
        respond(32'h1);
        @(negedge clk);
        chk("full_pop_req", bus_req, 1'b0);
        chk("full_pop_rv", host_rvalid, 2'b01);
        cyc();
        idle_bus();
        @(negedge clk);
        chk("full_after_req", bus_req, 1'b1);
        chk("full_after_gnt", host_gnt, 2'b01);
        cyc();
        for (int k = 0; k < 4; k++) begin
            respond(32'h2 + k);
            cyc();
        end
        idle_bus();

        // Decode error behind two outstanding reads.
        issue(0, 32'h0010_0000, 1'b0, 32'h0);
        cyc();
        issue(0, 32'h0010_0004, 1'b0, 32'h0);
        cyc();
        issue(1, 32'h0011_0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("de_wait_gnt", host_gnt, 2'b00);
        chk("de_wait_req", bus_req, 1'b0);
        cyc();
        respond(32'h11);
        @(negedge clk);
        chk("de_pop1_gnt", host_gnt, 2'b00);
        cyc();
        respond(32'h22);
        @(negedge clk);
        chk("de_pop2_gnt", host_gnt, 2'b00);
        cyc();
        idle_bus();
        @(negedge clk);
        chk("de_gnt", host_gnt, 2'b10);
        chk("de_no_fwd", bus_req, 1'b0);
        cyc();
        @(negedge clk);
        chk("de_rvalid", host_rvalid, 2'b10);
        chk("de_err", host_err, 2'b10);
        chk("de_rdata", host_rdata, 64'h0);
        cyc();

        // Reset with three reads in flight.
        for (int k = 0; k < 3; k++) begin
            issue(0, 32'h0010_0300 + 4 * k, 1'b0, 32'h0);
            cyc();
        end
        host_req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_gnt", host_gnt, 2'b00);
        chk("rst2_req", bus_req, 1'b0);
        chk("rst2_rvalid", host_rvalid, 2'b00);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        issue(0, 32'h0010_0400, 1'b0, 32'h0);
        issue(1, 32'h0010_0500, 1'b0, 32'h0);
        @(negedge clk);
        chk("post_rst_gnt", host_gnt, 2'b01);
        cyc();
        @(negedge clk);
        chk("post_rst_gnt1", host_gnt, 2'b10);
        cyc();
        respond(32'hAAAA_0000);
        @(negedge clk);
        chk("post_rst_rv0", host_rvalid, 2'b01);
        cyc();
        respond(32'hBBBB_0000);
        @(negedge clk);
        chk("post_rst_rv1", host_rvalid, 2'b10);
        cyc();
        idle_bus();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
